// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared CPU definitions for the register write-back path:
// state encoding and default widths / load timeout.
package reg_writeback_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_REQ = 2'd1,
    COMMIT  = 2'd2
  } wb_state_t;

  localparam int DATA_W_DEF  = 8;
  localparam int RADDR_W_DEF = 3;
  localparam int MADDR_W_DEF = 8;
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-port master: commits ALU results directly,
// fetches load data over the memory handshake with a timeout.
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int MADDR_W = MADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               REQ_VALID,
  input  logic               REQ_IS_LOAD,
  input  logic [RADDR_W-1:0] REQ_DEST,
  input  logic [DATA_W-1:0]  ALU_RESULT,
  output logic               BUSYWAIT,
  output logic               MEM_READ,
  output logic [MADDR_W-1:0] MEM_ADDRESS,
  input  logic [DATA_W-1:0]  MEM_READDATA,
  input  logic               MEM_BUSYWAIT,
  output logic [DATA_W-1:0]  RF_IN,
  output logic [RADDR_W-1:0] RF_INADDRESS,
  output logic               RF_WRITE,
  output logic               ERR
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  wb_state_t  state;
  logic [7:0] cnt;
  logic       accept;

  assign accept = ((state == IDLE) || (state == COMMIT)) && REQ_VALID;

  // Stall the CPU while a load is outstanding or being accepted.
  assign BUSYWAIT = (state == MEM_REQ) || (accept && REQ_IS_LOAD);

  // Write-back FSM with registered memory and register-file ports.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      cnt          <= '0;
      MEM_READ     <= 1'b0;
      MEM_ADDRESS  <= '0;
      RF_IN        <= '0;
      RF_INADDRESS <= '0;
      RF_WRITE     <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      RF_WRITE <= 1'b0;
      case (state)
        MEM_REQ: begin
          cnt <= cnt + 8'd1;
          if (!MEM_BUSYWAIT) begin
            RF_IN    <= MEM_READDATA;
            MEM_READ <= 1'b0;
            RF_WRITE <= 1'b1;
            state    <= COMMIT;
          end else if (cnt == TO_LAST) begin
            MEM_READ <= 1'b0;
            ERR      <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          if (accept) begin
            RF_INADDRESS <= REQ_DEST;
            if (REQ_IS_LOAD) begin
              MEM_ADDRESS <= ALU_RESULT[MADDR_W-1:0];
              MEM_READ    <= 1'b1;
              cnt         <= '0;
              state       <= MEM_REQ;
            end else begin
              RF_IN    <= ALU_RESULT;
              RF_WRITE <= 1'b1;
              state    <= COMMIT;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed scenarios plus random
// traffic against a transaction-level model and register file.
module tb_reg_writeback_ctrl;

  localparam int TO = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_IS_LOAD = 1'b0;
  logic [2:0] REQ_DEST = '0;
  logic [7:0] ALU_RESULT = '0;
  logic       BUSYWAIT;
  logic       MEM_READ;
  logic [7:0] MEM_ADDRESS;
  logic [7:0] MEM_READDATA = '0;
  logic       MEM_BUSYWAIT = 1'b1;
  logic [7:0] RF_IN;
  logic [2:0] RF_INADDRESS;
  logic       RF_WRITE;
  logic       ERR;

  int checks = 0;
  int errors = 0;

  reg_writeback_ctrl #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_IS_LOAD(REQ_IS_LOAD),
    .REQ_DEST(REQ_DEST), .ALU_RESULT(ALU_RESULT),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .RF_IN(RF_IN),
    .RF_INADDRESS(RF_INADDRESS), .RF_WRITE(RF_WRITE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // The register file the block drives (environment fixture).
  logic [7:0] rf [8];
  initial for (int i = 0; i < 8; i++) rf[i] = '0;
  always @(posedge CLK) if (RF_WRITE) rf[RF_INADDRESS] <= RF_IN;

  // Transaction-level reference: a load in flight, how many memory
  // edges it has waited, and the write expected to land next edge.
  logic [7:0] exp_rf [8];
  bit         known = 0;
  bit         loading;
  int         waited;
  bit         e_we;
  logic [2:0] e_rd;
  logic [7:0] e_in;
  logic [7:0] e_addr;
  bit         e_mread;
  bit         e_err;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input bit rst, input bit v, input bit ld,
                            input logic [2:0] d, input logic [7:0] a,
                            input bit mb, input logic [7:0] md);
    if (e_we) exp_rf[e_rd] = e_in;
    if (rst) begin
      loading = 0; waited = 0; e_we = 0; e_rd = '0; e_in = '0;
      e_addr = '0; e_mread = 0; e_err = 0; known = 1;
    end else if (loading) begin
      waited++;
      e_we = 0;
      if (!mb) begin
        e_in = md; e_mread = 0; loading = 0; e_we = 1;
      end else if (waited == TO) begin
        e_mread = 0; loading = 0; e_err = 1;
      end
    end else if (v) begin
      e_rd = d;
      if (ld) begin
        loading = 1; waited = 0; e_addr = a; e_mread = 1; e_we = 0;
      end else begin
        e_in = a; e_we = 1;
      end
    end else begin
      e_we = 0;
    end
  endtask

  task automatic step(input bit rst, input bit v, input bit ld,
                      input logic [2:0] d, input logic [7:0] a,
                      input bit mb, input logic [7:0] md);
    RESET = rst; REQ_VALID = v; REQ_IS_LOAD = ld; REQ_DEST = d;
    ALU_RESULT = a; MEM_BUSYWAIT = mb; MEM_READDATA = md;
    #2;
    if (known && !rst)
      chk("busywait", {7'd0, BUSYWAIT},
          {7'd0, loading || (v && ld)});
    @(posedge CLK);
    model_edge(rst, v, ld, d, a, mb, md);
    #1;
    chk("rf_write", {7'd0, RF_WRITE}, {7'd0, e_we});
    chk("mem_read", {7'd0, MEM_READ}, {7'd0, e_mread});
    chk("err", {7'd0, ERR}, {7'd0, e_err});
    chk("mem_addr", MEM_ADDRESS, e_addr);
    chk("rf_in", RF_IN, e_in);
    chk("rf_inaddr", {5'd0, RF_INADDRESS}, {5'd0, e_rd});
    for (int i = 0; i < 8; i++)
      chk($sformatf("rf[%0d]", i), rf[i], exp_rf[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_rf[i] = '0;
    #1;
    // Reset held two cycles with a request present.
    step(1, 1, 0, 3, 8'h55, 1, 0);
    step(1, 1, 0, 4, 8'h66, 1, 0);
    chk("reset_busywait", {7'd0, BUSYWAIT}, 8'd0);
    idle(1);

    // Back-to-back ALU writes.
    step(0, 1, 0, 3, 8'h2A, 1, 0);
    step(0, 1, 0, 5, 8'h11, 1, 0);
    idle(2);
    chk("r3", rf[3], 8'h2A);
    chk("r5", rf[5], 8'h11);

    // Load r2 from 0x40, memory busy three edges then 0x9C.
    step(0, 1, 1, 2, 8'h40, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 6, 8'hEE, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 8'h9C);
    idle(2);
    chk("r2", rf[2], 8'h9C);

    // ALU write then load to the same register from COMMIT.
    step(0, 1, 0, 1, 8'h07, 1, 0);
    step(0, 1, 1, 1, 8'h80, 1, 0);
    chk("r1_alu", rf[1], 8'h07);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 8'hC3);
    idle(2);
    chk("r1_load", rf[1], 8'hC3);

    // Reset during an outstanding load.
    step(0, 1, 1, 7, 8'h10, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 8'hAA);
    idle(2);
    chk("r7_untouched", rf[7], 8'h00);

    // Load timeout with memory held busy.
    step(0, 1, 1, 4, 8'h20, 1, 0);
    for (int i = 0; i < TO; i++) step(0, 0, 0, 0, 0, 1, 0);
    chk("timeout_err", {7'd0, ERR}, 8'd1);
    idle(3);
    step(0, 1, 0, 0, 8'h3B, 1, 0);
    idle(1);
    chk("err_sticky", {7'd0, ERR}, 8'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 60) == 0),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           3'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0), 8'($urandom));
    end

    step(1, 0, 0, 0, 0, 1, 0);
    chk("err_cleared", {7'd0, ERR}, 8'd0);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
